uart_tx_rr_sched: RTL and testbench

- Round-robin scheduler that shares one UART transmit engine between NUM_REQ byte-stream requesters.
- Grants one requester per packet and holds the grant until that requester's last byte completes.
- Hands the engine one byte at a time with a start pulse and waits for its done pulse.
- Inserts a programmable inter-packet idle gap, measured in bit times, and guards each byte with a watchdog.

---
 rtl/uart_tx_rr_sched.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_rr_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_rr_sched.sv
// Round-robin arbiter feeding one UART transmit engine from NUM_REQ byte streams.
// A grant lasts one whole packet; an idle gap and a per-byte watchdog follow it.
module uart_tx_rr_sched #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                   sys_clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [15:0]            baud_cnt_max,
  input  logic [3:0]             gap_bits_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_done_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_DONE, S_HOLD, S_GAP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [IW-1:0]           r_ptr, r_gidx;
  logic [NUM_REQ-1:0]      r_grant;
  logic [7:0]              r_data;
  logic                    r_last;
  logic [19:0]             r_wd, r_gap_cnt, r_gap_lim;

  logic [NUM_REQ-1:0][7:0] w_bytes;
  logic [IW:0]             w_sum;
  logic [IW-1:0]           w_pick;
  logic                    w_pick_ok;
  logic [NUM_REQ-1:0]      w_pick_oh;
  logic                    w_gvalid, w_glast;
  logic [7:0]              w_gbyte;
  logic [19:0]             w_bcm, w_wd_lim, w_gap_lim;
  logic                    w_wd_hit, w_gap_done;
  logic                    w_take, w_load, w_fin, w_release, w_timeout;

  assign w_bytes = req_data_i;

  // Scan ptr+1, ptr+2, ... with wraparound; first valid requester wins.
  always_comb begin
    w_pick_ok = 1'b0;
    w_pick    = '0;
    w_sum     = '0;
    w_pick_oh = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NUM_REQ)) w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (!w_pick_ok && req_valid_i[w_sum[IW-1:0]]) begin
        w_pick_ok = 1'b1;
        w_pick    = w_sum[IW-1:0];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) w_pick_oh[k] = (w_pick == IW'(k));
  end

  assign w_gvalid = |(req_valid_i & r_grant);
  assign w_glast  = |(req_last_i & r_grant);
  assign w_gbyte  = w_bytes[r_gidx];

  assign w_bcm      = (baud_cnt_max == 16'd0) ? 20'd1 : {4'd0, baud_cnt_max};
  assign w_wd_lim   = 20'(TIMEOUT_BITS) * w_bcm;
  assign w_gap_lim  = {16'd0, gap_bits_i} * w_bcm;
  assign w_wd_hit   = (r_wd + 20'd1) >= w_wd_lim;
  assign w_gap_done = (r_gap_cnt + 20'd1) >= r_gap_lim;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_load      = 1'b0;
    w_fin       = 1'b0;
    w_timeout   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_ok) begin
          w_take      = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // The watchdog wins over a done arriving in the same cycle.
        if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_fin     = 1'b1;
        end else if (tx_done_i) begin
          if (r_last) begin
            w_fin = 1'b1;
          end else if (w_gvalid) begin
            w_load      = 1'b1;
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_fin     = 1'b1;
        end else if (w_gvalid) begin
          w_load      = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_GAP: begin
        if (w_gap_done) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A zero-length gap skips GAP entirely so the next grant comes one cycle sooner.
    if (w_fin) begin
      if (w_gap_lim == 20'd0) begin
        w_release   = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_GAP;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr     <= IW'(NUM_REQ-1);
      r_gidx    <= '0;
      r_grant   <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_wd      <= '0;
      r_gap_cnt <= '0;
      r_gap_lim <= '0;
    end else begin
      if (w_take) begin
        r_grant <= w_pick_oh;
        r_gidx  <= w_pick;
        r_ptr   <= w_pick;
        r_data  <= w_bytes[w_pick];
      end
      if (w_load) r_data <= w_gbyte;
      case (r_state)
        S_LOAD: begin
          r_last <= w_glast;
          r_wd   <= '0;
        end
        S_WAIT_DONE, S_HOLD: r_wd      <= r_wd + 20'd1;
        S_GAP:               r_gap_cnt <= r_gap_cnt + 20'd1;
        default: ;
      endcase
      if (w_fin) begin
        r_gap_lim <= w_gap_lim;
        r_gap_cnt <= '0;
      end
      if (w_release) r_grant <= '0;
    end
  end

  assign tx_start_o  = (r_state == S_LOAD);
  assign req_ready_o = (r_state == S_LOAD) ? r_grant : '0;
  assign tx_data_o   = r_data;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state != S_IDLE);
  assign timeout_o   = w_timeout;

endmodule

// File: tb/tb_uart_tx_rr_sched.sv
// Directed + randomized bench for uart_tx_rr_sched; a packet-level model of
// requesters, engine and arbitration rules checks every cycle.
module tb_uart_tx_rr_sched;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   vld, lst, rdy, grant;
  logic [8*N-1:0] dat;
  logic [15:0]    baud;
  logic [3:0]     gap;
  logic           start, done, busy, tout;
  logic [7:0]     txd;

  uart_tx_rr_sched #(.NUM_REQ(N), .TIMEOUT_BITS(TO)) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .req_valid_i(vld), .req_data_i(dat),
    .req_last_i(lst), .req_ready_o(rdy), .baud_cnt_max(baud), .gap_bits_i(gap),
    .tx_start_o(start), .tx_data_o(txd), .tx_done_i(done), .grant_o(grant),
    .busy_o(busy), .timeout_o(tout));

  int total = 0, bad = 0;
  logic [8:0]  q[N][$];
  logic [11:0] log_q[$];
  logic [N-1:0] hold, rdy_prev, prev_valid;
  logic done_prev;
  int cyc = 0, owner, last_owner, exp_rel, deadline, eng_cnt, eng_dly;
  int nstart, nto, to_cyc, st_cyc, last_done_cyc, gap_obs, rel_cyc;
  int rdy_cnt[N];
  bit ending, pending, cur_last, eng_en, rand_dly, force_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcm_f();  return (baud == 16'd0) ? 1 : int'(baud); endfunction
  function automatic int gap_f();  return int'(gap) * bcm_f();              endfunction
  function automatic int lim_f();  return TO * bcm_f();                     endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int from);
    for (int i = 1; i <= N; i++) if (v[(from + i) % N]) return (from + i) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [11:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 12'hFFF;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0 && !hold[k]) begin
        vld[k] = 1'b1; dat[8*k +: 8] = q[k][0][7:0]; lst[k] = q[k][0][8];
      end else begin
        vld[k] = 1'b0; dat[8*k +: 8] = 8'h00; lst[k] = 1'b0;
      end
    end
  endtask

  // One clock: retire consumed bytes, check this cycle's outputs, then drive the next.
  task automatic tick();
    int  e;
    bit  exp_to;
    prev_valid = vld;
    done_prev  = done;
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < N; k++) if (rdy_prev[k] && q[k].size() > 0) void'(q[k].pop_front());
    if (done_prev && pending) begin
      pending = 1'b0;
      if (cur_last) begin ending = 1'b1; exp_rel = cyc + gap_f(); end
    end
    if (owner >= 0 && ending && cyc == exp_rel) begin
      chk("release_grant", grant, 0);
      chk("release_busy", busy, 0);
      owner = -1; ending = 1'b0; rel_cyc = cyc;
    end else if (owner >= 0) begin
      chk("grant_locked", grant, 1 << owner);
    end else if (grant != '0) begin
      e = rr_pick(prev_valid, last_owner);
      chk("rr_pick", grant, (e < 0) ? 0 : (1 << e));
      owner = e;
      if (e >= 0) last_owner = e;
    end else begin
      chk("idle_busy", busy, 0);
    end
    if (start) begin
      nstart++;
      st_cyc  = cyc;
      gap_obs = cyc - last_done_cyc;
      chk("start_ready", rdy, grant);
      chk("start_has_byte", (owner >= 0) ? q[owner].size() : 0, (owner >= 0 && q[owner].size() > 0) ? q[owner].size() : 1);
      if (owner >= 0 && q[owner].size() > 0) begin
        chk("start_data", txd, q[owner][0][7:0]);
        cur_last = q[owner][0][8];
        log_q.push_back({4'(owner), q[owner][0][7:0]});
      end
      pending  = 1'b1;
      deadline = cyc + lim_f();
    end else begin
      chk("ready_quiet", rdy, 0);
    end
    exp_to = (owner >= 0) && !ending && !start && (cyc == deadline);
    chk("timeout", tout, exp_to);
    if (tout && owner >= 0 && !ending) begin
      ending = 1'b1; pending = 1'b0; exp_rel = cyc + 1 + gap_f(); nto++; to_cyc = cyc;
    end
    rdy_prev = rdy;
    for (int k = 0; k < N; k++) if (rdy[k]) rdy_cnt[k]++;
    done = 1'b0;
    if (start && eng_en) eng_cnt = rand_dly ? int'($urandom_range(1, 6)) : eng_dly;
    else if (eng_cnt > 0) begin eng_cnt--; if (eng_cnt == 0) done = 1'b1; end
    if (force_done) done = 1'b1;
    if (done) last_done_cyc = cyc;
    drive();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (!(all_empty() && !busy) && n < budget) begin tick(); n++; end
    chk("idle_reached", n < budget, 1);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    do begin tick(); n++; end while (!start && n < budget);
    chk("start_seen", start, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_ready"}, rdy, 0);
    chk({tag, "_tout"}, tout, 0);
    chk({tag, "_data"}, txd, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hold = '0; force_done = 1'b0; eng_cnt = 0; done = 1'b0;
    for (int k = 0; k < N; k++) begin q[k].delete(); rdy_cnt[k] = 0; end
    drive();
    owner = -1; last_owner = N-1; ending = 1'b0; pending = 1'b0; rdy_prev = '0;
    deadline = -1; exp_rel = -1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    chk("release_no_start", start, 0);
    log_q.delete(); nstart = 0; nto = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_time_limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] b[3];
    int exp_own[6];
    int nbytes, k, len, n;
    rst_n = 1'b0; vld = '0; lst = '0; dat = '0; done = 1'b0; hold = '0;
    baud = 16'd10; gap = 4'd2; eng_en = 1'b1; rand_dly = 1'b0; eng_dly = 5;
    last_done_cyc = 0; rel_cyc = 0;

    // Single two-byte packet from requester 1, 20-cycle gap.
    do_reset();
    q[1].push_back({1'b0, 8'hA5}); q[1].push_back({1'b1, 8'h3C}); drive();
    run_idle(500);
    chk("t1_starts", nstart, 2);
    chk("t1_byte0", log_at(0), {4'd1, 8'hA5});
    chk("t1_byte1", log_at(1), {4'd1, 8'h3C});
    chk("t1_ready1", rdy_cnt[1], 2);
    chk("t1_gap", rel_cyc - last_done_cyc, 21);

    // Round robin over 0, 2, 3 with single-byte packets and no gap.
    do_reset(); gap = 4'd0; baud = 16'd3; rand_dly = 1'b1;
    for (int p = 0; p < 2; p++) begin
      q[0].push_back({1'b1, 8'($urandom)});
      q[2].push_back({1'b1, 8'($urandom)});
      q[3].push_back({1'b1, 8'($urandom)});
    end
    drive(); run_idle(1000);
    exp_own = '{0, 2, 3, 0, 2, 3};
    for (int i = 0; i < 6; i++) chk("t2_order", log_at(i) >> 8, exp_own[i]);

    // Packet lock: requester 0 stalls between bytes while requester 1 waits.
    do_reset(); gap = 4'd1; baud = 16'd2; rand_dly = 1'b0; eng_dly = 5;
    for (int i = 0; i < 3; i++) begin b[i] = 8'($urandom); q[0].push_back({i == 2, b[i]}); end
    q[1].push_back({1'b1, 8'h77}); drive();
    n = 0;
    do begin tick(); n++; end while (!rdy[0] && n < 50);
    chk("t3_first_ready", rdy, 4'b0001);
    tick(); hold[0] = 1'b1; drive();
    repeat (7) begin tick(); chk("t3_lock_grant", grant, 4'b0001); chk("t3_no_start", start, 0); end
    hold[0] = 1'b0; drive();
    run_idle(500);
    for (int i = 0; i < 3; i++) chk("t3_req0_byte", log_at(i), {4'd0, b[i]});
    chk("t3_req1_after", log_at(3), {4'd1, 8'h77});

    // Watchdog: engine never answers.
    do_reset(); baud = 16'd4; gap = 4'd1; eng_en = 1'b0;
    q[0].push_back({1'b0, 8'($urandom)}); drive();
    n = 0;
    while (nto == 0 && n < 300) begin tick(); n++; end
    chk("t4_to_count", nto, 1);
    chk("t4_to_latency", to_cyc - st_cyc, 64);
    tick(); force_done = 1'b1; tick(); force_done = 1'b0;
    run_idle(200);
    repeat (5) tick();
    chk("t4_no_restart", nstart, 1);
    chk("t4_idle", busy, 0);
    eng_en = 1'b1;

    // Reset in the middle of a byte.
    do_reset(); baud = 16'd10; gap = 4'd2; eng_dly = 5;
    q[2].push_back({1'b1, 8'($urandom)}); drive();
    wait_start(50); tick(); tick();
    rst_n = 1'b0; #1;
    chk_zero("midrst");
    do_reset();
    q[0].push_back({1'b1, 8'($urandom)}); q[3].push_back({1'b1, 8'($urandom)}); drive();
    run_idle(500);
    chk("t5_first", log_at(0) >> 8, 0);
    chk("t5_second", log_at(1) >> 8, 3);

    // Zero gap with zero baud count: done to next start in two cycles.
    do_reset(); gap = 4'd0; baud = 16'd0; eng_dly = 2;
    q[1].push_back({1'b1, 8'($urandom)}); q[2].push_back({1'b1, 8'($urandom)}); drive();
    run_idle(200);
    chk("t6_starts", nstart, 2);
    chk("t6_done_to_start", gap_obs, 2);

    // Random packets from all requesters.
    do_reset(); baud = 16'($urandom_range(0, 3)); gap = 4'($urandom_range(0, 3)); rand_dly = 1'b1;
    nbytes = 0;
    for (int p = 0; p < 12; p++) begin
      k = $urandom_range(0, N-1); len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) q[k].push_back({i == len-1, 8'($urandom)});
      nbytes += len;
    end
    drive(); run_idle(5000);
    chk("t7_bytes", log_q.size(), nbytes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
